usb_xbar_pkt: RTL and testbench
===============================

// Module: usb_xbar_pkt
// PURPOSE
//  Parametrised N-source x M-sink byte-stream crossbar between the USB hosts and the parsers.
//  Each sink has a registered select that changes only at packet boundaries, so no packet
//  is ever split or joined mid-stream. A packet is a contiguous run of dv=1 cycles.
//  An optional timeout forces a switch away from a source that never goes idle.
//  Outputs are registered with 1-cycle latency; a sink may also be disconnected.
// PARAMETERS
//  N     5   number of sources
//  M     4   number of sinks
//  DW    8   data width per source/sink
//  SELW  3   select width; must satisfy 2**SELW > N; any sel value >= N means disconnected
//  TMO   0   blocked-switch timeout in cycles; 0 = never force a switch
//  TCW   16  timeout counter width; requires TMO < 2**TCW
// PORTS
//  c     in   1       clock; all state changes on rising edge
//  rn    in   1       reset: asynchronous assert, active-low
//  sel   in   M*SELW  requested source per sink; slice k = sel[k*SELW +: SELW]; sampled every cycle
//  d     in   N*DW    source data; slice i = d[i*DW +: DW]
//  dv    in   N       source data-valid
//  q     out  M*DW    sink data, registered
//  qv    out  M       sink data-valid, registered
//  act   out  M*SELW  committed (active) select per sink
//  pend  out  M       sel_k != act_k; combinational
//  err   out  M       one-cycle pulse when a timeout forces a switch
// BEHAVIOUR
//  Reset (rn=0, async): act_k = all-ones, state_k = OFF, q = 0, qv = 0, err = 0, tcnt_k = 0.
//  Notation: s = act_k; src_dv = dv[s] if s < N, else 0.
//  Per-sink FSM (OFF / WAIT / PASS). "Commit" means: act_k <= sel_k, tcnt_k <= 0,
//   next state = OFF if sel_k >= N; else PASS if dv[sel_k] = 0 this cycle; else WAIT.
//  OFF:  qv_k <= 0, q_k <= 0. If pend_k, commit at this edge.
//  WAIT: joined a source that is mid-packet. q_k <= d[s], qv_k <= 0.
//   If pend_k, commit. Else if src_dv = 0, go to PASS.
//  PASS: q_k <= d[s], qv_k <= src_dv.
//   If pend_k and src_dv = 0, commit.
//   If pend_k and src_dv = 1, the sink is blocked: tcnt_k++.
//   If TMO != 0 and this is the TMO-th consecutive blocked cycle: force a commit at this edge,
//   qv_k <= 0 (packet truncated), err_k <= 1 for one cycle.
//  tcnt_k clears whenever pend_k = 0 or a commit occurs.
//  Latency: the byte on d/dv at cycle t appears on q/qv at t+1 (PASS only).
//  Commit cycle: the mux still uses the old s, whose dv is 0 except on a forced commit, where
//   qv is forced 0. The new source's first forwarded byte is taken the cycle after the commit.
//  A packet on the new source that starts the cycle after a commit is forwarded whole.
//  Fan-out: any number of sinks may select the same source; each sink is independent.
//  sel returning to act_k before a commit cancels the switch; pend_k drops and there is no glitch.
//  A sel value >= N (including 5..7 at the defaults) yields OFF; qv_k stays 0.
//  Reset asserted mid-packet: outputs clear immediately. After release, each sink with
//   sel_k < N commits on the first edge.
//  With TMO = 0, a sink blocked behind a permanently-valid source waits indefinitely;
//   pend_k stays high.
// TESTING
//  1 Reset: rn=0 with random d/dv -> q=0, qv=0, act=all 7, err=0. Hold after release with
//    sel=all 7 -> outputs stay 0.
//  2 sel0=2, src2 idle -> act0=2 after 1 edge, PASS. Send AA,BB,CC,DD on src2 ->
//    qv0 high 4 cycles, one cycle later; q0 = AA..DD.
//  3 src2 sending 6 bytes; set sel0=3 at byte 2 -> all 6 bytes still reach q0, pend0=1
//    meanwhile. act0=3 on the first idle cycle; the next src3 packet 11,22 is forwarded intact.
//  4 Sink OFF; set sel1=1 while src1 is mid-packet -> WAIT, qv1=0 for the rest of that packet.
//    The next src1 packet is forwarded in full.
//  5 TMO=8: src2 dv held high, sel0 changes from 2 to 0 -> pend0 high for 8 cycles, then
//    forced commit: err0 pulses once, qv0=0 at the commit edge, act0=0.
//  6 sel=4 on all sinks, src4 sends 5A,A5 -> identical q on all 4 sinks. sel1=6 -> sink1 OFF
//    (qv1=0) while the others are unaffected.

Source files
------------

// File: rtl/usb_xbar_pkt.sv
// N-source x M-sink byte-stream crossbar; each sink switches source only between packets,
// with an optional timeout that forces a switch away from a source that never idles.
module usb_xbar_pkt #(
    parameter int N    = 5,
    parameter int M    = 4,
    parameter int DW   = 8,
    parameter int SELW = 3,
    parameter int TMO  = 0,
    parameter int TCW  = 16
) (
    input  logic              c,
    input  logic              rn,
    input  logic [M*SELW-1:0] sel,
    input  logic [N*DW-1:0]   d,
    input  logic [N-1:0]      dv,
    output logic [M*DW-1:0]   q,
    output logic [M-1:0]      qv,
    output logic [M*SELW-1:0] act,
    output logic [M-1:0]      pend,
    output logic [M-1:0]      err
);

    typedef enum logic [1:0] {S_OFF, S_WAIT, S_PASS} state_e;

    localparam logic [SELW-1:0] NSEL  = SELW'(N);
    localparam logic [TCW-1:0]  TLAST = (TMO == 0) ? '0 : TCW'(TMO - 1);

    state_e          state_q [M];
    state_e          state_d [M];
    logic [SELW-1:0] act_q   [M];
    logic [SELW-1:0] act_d   [M];
    logic [TCW-1:0]  tcnt_q  [M];
    logic [TCW-1:0]  tcnt_d  [M];
    logic [DW-1:0]   q_q     [M];
    logic [DW-1:0]   q_d     [M];
    logic [M-1:0]    qv_q, qv_d, err_q, err_d;

    logic [SELW-1:0] sel_a   [M];
    logic [DW-1:0]   src_d   [M];
    logic [M-1:0]    src_dv, new_dv, cmt;

    // Out-of-range indices read as an idle, all-zero source.
    function automatic logic src_valid(input logic [SELW-1:0] idx, input logic [N-1:0] v);
        src_valid = 1'b0;
        for (int unsigned i = 0; i < N; i++)
            if (idx == SELW'(i)) src_valid = v[i];
    endfunction

    function automatic logic [DW-1:0] src_data(input logic [SELW-1:0] idx, input logic [N*DW-1:0] x);
        src_data = '0;
        for (int unsigned i = 0; i < N; i++)
            if (idx == SELW'(i)) src_data = x[i*DW +: DW];
    endfunction

    always_comb begin
        for (int unsigned k = 0; k < M; k++) begin
            sel_a[k]             = sel[k*SELW +: SELW];
            pend[k]              = sel_a[k] != act_q[k];
            src_dv[k]            = src_valid(act_q[k], dv);
            src_d[k]             = src_data(act_q[k], d);
            new_dv[k]            = src_valid(sel_a[k], dv);
            act[k*SELW +: SELW]  = act_q[k];
            q[k*DW +: DW]        = q_q[k];
        end
    end

    assign qv  = qv_q;
    assign err = err_q;

    always_comb begin
        for (int unsigned k = 0; k < M; k++) begin
            state_d[k] = state_q[k];
            act_d[k]   = act_q[k];
            tcnt_d[k]  = '0;
            q_d[k]     = src_d[k];
            qv_d[k]    = 1'b0;
            err_d[k]   = 1'b0;
            cmt[k]     = 1'b0;
            unique case (state_q[k])
                S_OFF: begin
                    q_d[k] = '0;
                    cmt[k] = pend[k];
                end
                S_WAIT: begin
                    if (pend[k])        cmt[k]     = 1'b1;
                    else if (!src_dv[k]) state_d[k] = S_PASS;
                end
                S_PASS: begin
                    qv_d[k] = src_dv[k];
                    if (pend[k]) begin
                        if (!src_dv[k]) begin
                            cmt[k] = 1'b1;
                        end else if (TMO != 0 && tcnt_q[k] == TLAST) begin
                            // Forced switch truncates the packet in flight.
                            cmt[k]   = 1'b1;
                            qv_d[k]  = 1'b0;
                            err_d[k] = 1'b1;
                        end else begin
                            tcnt_d[k] = tcnt_q[k] + 1'b1;
                        end
                    end
                end
                default: state_d[k] = S_OFF;
            endcase
            if (cmt[k]) begin
                act_d[k]  = sel_a[k];
                tcnt_d[k] = '0;
                if (sel_a[k] >= NSEL) state_d[k] = S_OFF;
                else if (new_dv[k])   state_d[k] = S_WAIT;
                else                  state_d[k] = S_PASS;
            end
        end
    end

    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            for (int unsigned k = 0; k < M; k++) begin
                state_q[k] <= S_OFF;
                act_q[k]   <= '1;
                tcnt_q[k]  <= '0;
                q_q[k]     <= '0;
            end
            qv_q  <= '0;
            err_q <= '0;
        end else begin
            for (int unsigned k = 0; k < M; k++) begin
                state_q[k] <= state_d[k];
                act_q[k]   <= act_d[k];
                tcnt_q[k]  <= tcnt_d[k];
                q_q[k]     <= q_d[k];
            end
            qv_q  <= qv_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_usb_xbar_pkt.sv
// Bench for usb_xbar_pkt: two instances (TMO=8 and TMO=0) share stimulus; vectors carry
// hand-derived expectations through a scoreboard queue, timeout and reset are hand sequences.
module tb_usb_xbar_pkt;

    localparam int N = 5, M = 4, DW = 8, SELW = 3;

    logic          c = 1'b0;
    logic          rn;
    logic [11:0]   sel;
    logic [39:0]   d;
    logic [4:0]    dv;
    logic [31:0]   q_a, q_b;
    logic [3:0]    qv_a, qv_b, pend_a, pend_b, err_a, err_b;
    logic [11:0]   act_a, act_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [11:0] sel;
        logic [39:0] d;
        logic [4:0]  dv;
        logic [31:0] q;
        logic [3:0]  qv;
        logic [11:0] act;
        logic [3:0]  pend;
        logic [3:0]  err;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   split;

    always #5 c = ~c;

    usb_xbar_pkt #(.N(N), .M(M), .DW(DW), .SELW(SELW), .TMO(8), .TCW(16)) dut_a (
        .c(c), .rn(rn), .sel(sel), .d(d), .dv(dv),
        .q(q_a), .qv(qv_a), .act(act_a), .pend(pend_a), .err(err_a)
    );

    usb_xbar_pkt #(.N(N), .M(M), .DW(DW), .SELW(SELW), .TMO(0), .TCW(16)) dut_b (
        .c(c), .rn(rn), .sel(sel), .d(d), .dv(dv),
        .q(q_b), .qv(qv_b), .act(act_b), .pend(pend_b), .err(err_b)
    );

    function automatic logic [11:0] s4(int a3, int a2, int a1, int a0);
        return {a3[2:0], a2[2:0], a1[2:0], a0[2:0]};
    endfunction

    function automatic vec_t mk(logic [11:0] s, int src, logic [7:0] b, logic v,
                                logic [31:0] eq, logic [3:0] eqv, logic [11:0] ea,
                                logic [3:0] ep, logic [3:0] ee);
        vec_t r;
        r.sel = s;
        r.d   = '0;
        r.dv  = '0;
        if (v) begin
            r.d[src*8 +: 8] = b;
            r.dv[src]       = 1'b1;
        end
        r.q    = eq;
        r.qv   = eqv;
        r.act  = ea;
        r.pend = ep;
        r.err  = ee;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic drive(logic [11:0] s, int src, logic [7:0] b, logic v);
        @(negedge c);
        sel = s;
        d   = '0;
        dv  = '0;
        if (v) begin
            d[src*8 +: 8] = b;
            dv[src]       = 1'b1;
        end
    endtask

    task automatic run_range(int lo, int hi);
        vec_t v, e;
        for (int i = lo; i < hi; i++) begin
            v = tbl[i];
            @(negedge c);
            sel = v.sel;
            d   = v.d;
            dv  = v.dv;
            sb.push_back(v);
            #1;
            chk($sformatf("v%0d pend_a", i), 32'(pend_a), 32'(v.pend));
            chk($sformatf("v%0d pend_b", i), 32'(pend_b), 32'(v.pend));
            @(posedge c);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d q_a", i),   q_a,          e.q);
            chk($sformatf("v%0d qv_a", i),  32'(qv_a),    32'(e.qv));
            chk($sformatf("v%0d act_a", i), 32'(act_a),   32'(e.act));
            chk($sformatf("v%0d err_a", i), 32'(err_a),   32'(e.err));
            chk($sformatf("v%0d q_b", i),   q_b,          e.q);
            chk($sformatf("v%0d qv_b", i),  32'(qv_b),    32'(e.qv));
            chk($sformatf("v%0d act_b", i), 32'(act_b),   32'(e.act));
            chk($sformatf("v%0d err_b", i), 32'(err_b),   32'(e.err));
        end
    endtask

    initial begin
        logic [7:0] b;

        // Idle after reset release, then single-packet forwarding on sink 0.
        repeat (2) tbl.push_back(mk(s4(7,7,7,7), 0, 8'h00, 0, 32'h0, 4'h0, 12'hFFF, 4'h0, 4'h0));
        tbl.push_back(mk(s4(7,7,7,2), 0, 8'h00, 0, 32'h0,  4'h0, s4(7,7,7,2), 4'b0001, 4'h0));
        tbl.push_back(mk(s4(7,7,7,2), 2, 8'hAA, 1, 32'hAA, 4'h1, s4(7,7,7,2), 4'b0000, 4'h0));
        tbl.push_back(mk(s4(7,7,7,2), 2, 8'hBB, 1, 32'hBB, 4'h1, s4(7,7,7,2), 4'b0000, 4'h0));
        tbl.push_back(mk(s4(7,7,7,2), 2, 8'hCC, 1, 32'hCC, 4'h1, s4(7,7,7,2), 4'b0000, 4'h0));
        tbl.push_back(mk(s4(7,7,7,2), 2, 8'hDD, 1, 32'hDD, 4'h1, s4(7,7,7,2), 4'b0000, 4'h0));
        tbl.push_back(mk(s4(7,7,7,2), 0, 8'h00, 0, 32'h0,  4'h0, s4(7,7,7,2), 4'b0000, 4'h0));
        // Switch requested mid-packet: packet finishes, commit on first idle cycle.
        tbl.push_back(mk(s4(7,7,7,2), 2, 8'h01, 1, 32'h01, 4'h1, s4(7,7,7,2), 4'b0000, 4'h0));
        for (int i = 2; i <= 6; i++) begin
            b = 8'(i);
            tbl.push_back(mk(s4(7,7,7,3), 2, b, 1, 32'(b), 4'h1, s4(7,7,7,2), 4'b0001, 4'h0));
        end
        tbl.push_back(mk(s4(7,7,7,3), 0, 8'h00, 0, 32'h0,  4'h0, s4(7,7,7,3), 4'b0001, 4'h0));
        tbl.push_back(mk(s4(7,7,7,3), 3, 8'h11, 1, 32'h11, 4'h1, s4(7,7,7,3), 4'b0000, 4'h0));
        tbl.push_back(mk(s4(7,7,7,3), 3, 8'h22, 1, 32'h22, 4'h1, s4(7,7,7,3), 4'b0000, 4'h0));
        tbl.push_back(mk(s4(7,7,7,3), 0, 8'h00, 0, 32'h0,  4'h0, s4(7,7,7,3), 4'b0000, 4'h0));
        // Sink 1 joins src1 mid-packet: WAIT hides the remainder, next packet passes.
        tbl.push_back(mk(s4(7,7,7,3), 1, 8'h31, 1, 32'h0,    4'h0,    s4(7,7,7,3), 4'b0000, 4'h0));
        tbl.push_back(mk(s4(7,7,1,3), 1, 8'h32, 1, 32'h0,    4'h0,    s4(7,7,1,3), 4'b0010, 4'h0));
        tbl.push_back(mk(s4(7,7,1,3), 1, 8'h33, 1, 32'h3300, 4'h0,    s4(7,7,1,3), 4'b0000, 4'h0));
        tbl.push_back(mk(s4(7,7,1,3), 0, 8'h00, 0, 32'h0,    4'h0,    s4(7,7,1,3), 4'b0000, 4'h0));
        tbl.push_back(mk(s4(7,7,1,3), 1, 8'h41, 1, 32'h4100, 4'b0010, s4(7,7,1,3), 4'b0000, 4'h0));
        tbl.push_back(mk(s4(7,7,1,3), 1, 8'h42, 1, 32'h4200, 4'b0010, s4(7,7,1,3), 4'b0000, 4'h0));
        tbl.push_back(mk(s4(7,7,1,3), 0, 8'h00, 0, 32'h0,    4'h0,    s4(7,7,1,3), 4'b0000, 4'h0));
        tbl.push_back(mk(s4(7,7,1,2), 0, 8'h00, 0, 32'h0,    4'h0,    s4(7,7,1,2), 4'b0001, 4'h0));
        tbl.push_back(mk(s4(7,7,1,2), 2, 8'h50, 1, 32'h50,   4'h1,    s4(7,7,1,2), 4'b0000, 4'h0));
        split = tbl.size();
        // Fan-out, disconnect via out-of-range select, cancelled switch.
        tbl.push_back(mk(s4(4,4,4,4), 0, 8'h00, 0, 32'h0,        4'h0,    s4(4,4,4,4), 4'b1111, 4'h0));
        tbl.push_back(mk(s4(4,4,4,4), 4, 8'h5A, 1, 32'h5A5A5A5A, 4'b1111, s4(4,4,4,4), 4'b0000, 4'h0));
        tbl.push_back(mk(s4(4,4,6,4), 4, 8'hA5, 1, 32'hA5A5A5A5, 4'b1111, s4(4,4,4,4), 4'b0010, 4'h0));
        tbl.push_back(mk(s4(4,4,6,4), 0, 8'h00, 0, 32'h0,        4'h0,    s4(4,4,6,4), 4'b0010, 4'h0));
        tbl.push_back(mk(s4(4,4,6,4), 4, 8'h5A, 1, 32'h5A5A005A, 4'b1101, s4(4,4,6,4), 4'b0000, 4'h0));
        tbl.push_back(mk(s4(4,3,6,4), 4, 8'h77, 1, 32'h77770077, 4'b1101, s4(4,4,6,4), 4'b0100, 4'h0));
        tbl.push_back(mk(s4(4,4,6,4), 4, 8'h78, 1, 32'h78780078, 4'b1101, s4(4,4,6,4), 4'b0000, 4'h0));
        tbl.push_back(mk(s4(4,4,6,4), 0, 8'h00, 0, 32'h0,        4'h0,    s4(4,4,6,4), 4'b0000, 4'h0));
        tbl.push_back(mk(s4(4,4,4,4), 0, 8'h00, 0, 32'h0,        4'h0,    s4(4,4,4,4), 4'b0010, 4'h0));

        // Reset with random traffic on the inputs.
        rn  = 1'b0;
        sel = s4(7,7,7,7);
        d   = '0;
        dv  = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge c);
            d  = 40'({$urandom(), $urandom()});
            dv = 5'($urandom());
            @(posedge c);
            #1;
            chk($sformatf("rst%0d q_a", i),   q_a,        32'h0);
            chk($sformatf("rst%0d qv_a", i),  32'(qv_a),  32'h0);
            chk($sformatf("rst%0d act_a", i), 32'(act_a), 32'hFFF);
            chk($sformatf("rst%0d err_a", i), 32'(err_a), 32'h0);
            chk($sformatf("rst%0d act_b", i), 32'(act_b), 32'hFFF);
        end
        drive(s4(7,7,7,7), 0, 8'h00, 0);
        rn = 1'b1;
        @(posedge c);
        #1;
        chk("rel act_a", 32'(act_a), 32'hFFF);

        run_range(0, split);

        // Timeout: src2 never idles while sink 0 asks for src0.
        for (int n = 0; n < 8; n++) begin
            b = 8'(8'h60 + n);
            drive(s4(7,7,1,0), 2, b, 1);
            #1;
            chk($sformatf("tmo%0d pend_a", n), 32'(pend_a[0]), 32'h1);
            chk($sformatf("tmo%0d pend_b", n), 32'(pend_b[0]), 32'h1);
            @(posedge c);
            #1;
            chk($sformatf("tmo%0d act_a", n), 32'(act_a[2:0]), (n == 7) ? 32'h0 : 32'h2);
            chk($sformatf("tmo%0d qv_a", n),  32'(qv_a[0]),    (n == 7) ? 32'h0 : 32'h1);
            chk($sformatf("tmo%0d err_a", n), 32'(err_a[0]),   (n == 7) ? 32'h1 : 32'h0);
            chk($sformatf("tmo%0d q_a", n),   32'(q_a[7:0]),   32'(b));
            chk($sformatf("tmo%0d act_b", n), 32'(act_b[2:0]), 32'h2);
            chk($sformatf("tmo%0d qv_b", n),  32'(qv_b[0]),    32'h1);
            chk($sformatf("tmo%0d err_b", n), 32'(err_b[0]),   32'h0);
        end
        drive(s4(7,7,1,0), 2, 8'h68, 1);
        #1;
        chk("tmo8 pend_a", 32'(pend_a[0]), 32'h0);
        chk("tmo8 pend_b", 32'(pend_b[0]), 32'h1);
        @(posedge c);
        #1;
        chk("tmo8 act_a", 32'(act_a[2:0]), 32'h0);
        chk("tmo8 qv_a",  32'(qv_a[0]),    32'h0);
        chk("tmo8 q_a",   32'(q_a[7:0]),   32'h0);
        chk("tmo8 err_a", 32'(err_a[0]),   32'h0);
        chk("tmo8 act_b", 32'(act_b[2:0]), 32'h2);
        chk("tmo8 qv_b",  32'(qv_b[0]),    32'h1);
        chk("tmo8 q_b",   32'(q_b[7:0]),   32'h68);
        drive(s4(7,7,1,0), 0, 8'h00, 0);
        @(posedge c);
        #1;
        chk("tmo9 act_a", 32'(act_a), 32'(s4(7,7,1,0)));
        chk("tmo9 act_b", 32'(act_b), 32'(s4(7,7,1,0)));
        chk("tmo9 qv_b",  32'(qv_b),  32'h0);

        run_range(split, tbl.size());

        // Asynchronous reset in the middle of a packet.
        drive(s4(4,4,4,4), 4, 8'h90, 1);
        @(posedge c);
        #1;
        chk("mid q_a",  q_a,       32'h90909090);
        chk("mid qv_a", 32'(qv_a), 32'hF);
        #2;
        rn = 1'b0;
        #1;
        chk("arst q_a",   q_a,        32'h0);
        chk("arst qv_a",  32'(qv_a),  32'h0);
        chk("arst act_a", 32'(act_a), 32'hFFF);
        chk("arst q_b",   q_b,        32'h0);
        @(posedge c);
        #1;
        chk("arst hold qv_a", 32'(qv_a), 32'h0);
        drive(s4(4,4,4,4), 0, 8'h00, 0);
        rn = 1'b1;
        @(posedge c);
        #1;
        chk("post act_a", 32'(act_a), 32'(s4(4,4,4,4)));
        chk("post qv_a",  32'(qv_a),  32'h0);
        drive(s4(4,4,4,4), 4, 8'h91, 1);
        @(posedge c);
        #1;
        chk("post q_a",  q_a,       32'h91919191);
        chk("post qv_a1", 32'(qv_a), 32'hF);
        chk("post q_b",  q_b,       32'h91919191);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
